// File: rtl/cdb_broadcast_stage.sv
// Completion stage: muxes the two selected FU results onto registered CDB lanes,
// acknowledges captured FUs, counts broadcasts and flags selector protocol errors.
module cdb_broadcast_stage #(
  parameter int FU_SIZE = 20,
  parameter int FU_CAT  = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic                      cdb_ready,
  input  logic [FU_SIZE-1:0]        fu_result_valid,
  input  logic [FU_SIZE*TAG_W-1:0]  fu_result_tag,
  input  logic [FU_SIZE*DATA_W-1:0] fu_result_value,
  input  logic [FU_SIZE-1:0]        fu_result_take_branch,
  input  logic [4:0]                fu_num_0,
  input  logic [4:0]                fu_num_1,
  input  logic [FU_CAT-1:0]         cat_select_0,
  input  logic [FU_CAT-1:0]         cat_select_1,
  output logic [FU_SIZE-1:0]        fu_result_ack,
  output logic                      cdb_valid_0,
  output logic                      cdb_valid_1,
  output logic [TAG_W-1:0]          cdb_tag_0,
  output logic [TAG_W-1:0]          cdb_tag_1,
  output logic [DATA_W-1:0]         cdb_value_0,
  output logic [DATA_W-1:0]         cdb_value_1,
  output logic                      cdb_take_branch_0,
  output logic                      cdb_take_branch_1,
  output logic                      cdb_is_branch_0,
  output logic                      cdb_is_branch_1,
  output logic [CNT_W-1:0]          bcast_count_0,
  output logic [CNT_W-1:0]          bcast_count_1,
  output logic                      protocol_error
);

  // FU slots each selector lane is wired to; the two sets partition 0..19.
  localparam logic [31:0] LANE0_OK = 32'h000A_5A55;
  localparam logic [31:0] LANE1_OK = 32'h0005_A5AA;

  logic [4:0]        num        [2];
  logic [FU_CAT-1:0] sel        [2];
  logic [TAG_W-1:0]  pick_tag   [2];
  logic [DATA_W-1:0] pick_value [2];
  logic [1:0]        pick_valid, pick_tb;
  logic [1:0]        grant, in_range, req, free, cap, multi_hot, bad_slot;
  logic              dup;

  logic [1:0]        valid_q, tb_q, br_q;
  logic [TAG_W-1:0]  tag_q   [2];
  logic [DATA_W-1:0] value_q [2];
  logic [CNT_W-1:0]  count_q [2];
  logic              error_q;

  assign num[0] = fu_num_0;
  assign num[1] = fu_num_1;
  assign sel[0] = cat_select_0;
  assign sel[1] = cat_select_1;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      pick_valid[k] = 1'b0;
      pick_tb[k]    = 1'b0;
      pick_tag[k]   = '0;
      pick_value[k] = '0;
      for (int i = 0; i < FU_SIZE; i++) begin
        if (int'(num[k]) == i) begin
          pick_valid[k] = fu_result_valid[i];
          pick_tb[k]    = fu_result_take_branch[i];
          pick_tag[k]   = fu_result_tag[i*TAG_W +: TAG_W];
          pick_value[k] = fu_result_value[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      grant[k]     = |sel[k];
      in_range[k]  = int'(num[k]) < FU_SIZE;
      req[k]       = grant[k] & in_range[k] & pick_valid[k];
      free[k]      = ~valid_q[k] | cdb_ready;
      multi_hot[k] = |(sel[k] & (sel[k] - FU_CAT'(1)));
    end
    bad_slot[0] = grant[0] & ~LANE0_OK[num[0]];
    bad_slot[1] = grant[1] & ~LANE1_OK[num[1]];
    dup    = grant[0] & grant[1] & (num[0] == num[1]);
    cap[0] = req[0] & free[0] & ~squash & ~reset;
    // Duplicate grant: lane 0 owns the FU so it is never captured twice.
    cap[1] = req[1] & free[1] & ~squash & ~reset & ~dup;
  end

  always_comb begin
    fu_result_ack = '0;
    for (int i = 0; i < FU_SIZE; i++) begin
      fu_result_ack[i] = (cap[0] && int'(num[0]) == i) || (cap[1] && int'(num[1]) == i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        valid_q[k] <= 1'b0;
        tb_q[k]    <= 1'b0;
        br_q[k]    <= 1'b0;
        tag_q[k]   <= '0;
        value_q[k] <= '0;
        count_q[k] <= '0;
      end
      error_q <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (valid_q[k] && cdb_ready && !squash && count_q[k] != '1)
          count_q[k] <= count_q[k] + CNT_W'(1);
        if (squash) begin
          valid_q[k] <= 1'b0;
        end else if (cap[k]) begin
          valid_q[k] <= 1'b1;
          tag_q[k]   <= pick_tag[k];
          value_q[k] <= pick_value[k];
          tb_q[k]    <= pick_tb[k];
          br_q[k]    <= sel[k][3];
        end else if (cdb_ready) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (dup || |bad_slot || |multi_hot)
        error_q <= 1'b1;
    end
  end

  assign cdb_valid_0       = valid_q[0];
  assign cdb_valid_1       = valid_q[1];
  assign cdb_tag_0         = tag_q[0];
  assign cdb_tag_1         = tag_q[1];
  assign cdb_value_0       = value_q[0];
  assign cdb_value_1       = value_q[1];
  assign cdb_take_branch_0 = tb_q[0];
  assign cdb_take_branch_1 = tb_q[1];
  assign cdb_is_branch_0   = br_q[0];
  assign cdb_is_branch_1   = br_q[1];
  assign bcast_count_0     = count_q[0];
  assign bcast_count_1     = count_q[1];
  assign protocol_error    = error_q;

endmodule

// File: tb/tb_cdb_broadcast_stage.sv
// Bench for cdb_broadcast_stage: directed scenarios with literal expectations,
// then randomized traffic against a lane-level behavioural model.
module tb_cdb_broadcast_stage;
  localparam int FU_SIZE = 20;
  localparam int FU_CAT  = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock = 1'b0, reset = 1'b1, squash = 1'b0, cdb_ready = 1'b0;
  logic [FU_SIZE-1:0]        fu_result_valid = '0, fu_result_take_branch = '0;
  logic [FU_SIZE*TAG_W-1:0]  fu_result_tag = '0;
  logic [FU_SIZE*DATA_W-1:0] fu_result_value = '0;
  logic [4:0]                fu_num_0 = '0, fu_num_1 = '0;
  logic [FU_CAT-1:0]         cat_select_0 = '0, cat_select_1 = '0;
  logic [FU_SIZE-1:0]        fu_result_ack;
  logic cdb_valid_0, cdb_valid_1, cdb_take_branch_0, cdb_take_branch_1;
  logic cdb_is_branch_0, cdb_is_branch_1, protocol_error;
  logic [TAG_W-1:0]  cdb_tag_0, cdb_tag_1;
  logic [DATA_W-1:0] cdb_value_0, cdb_value_1;
  logic [CNT_W-1:0]  bcast_count_0, bcast_count_1;

  cdb_broadcast_stage #(.FU_SIZE(FU_SIZE), .FU_CAT(FU_CAT), .TAG_W(TAG_W),
                        .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .squash(squash), .cdb_ready(cdb_ready),
    .fu_result_valid(fu_result_valid), .fu_result_tag(fu_result_tag),
    .fu_result_value(fu_result_value), .fu_result_take_branch(fu_result_take_branch),
    .fu_num_0(fu_num_0), .fu_num_1(fu_num_1),
    .cat_select_0(cat_select_0), .cat_select_1(cat_select_1),
    .fu_result_ack(fu_result_ack),
    .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
    .cdb_tag_0(cdb_tag_0), .cdb_tag_1(cdb_tag_1),
    .cdb_value_0(cdb_value_0), .cdb_value_1(cdb_value_1),
    .cdb_take_branch_0(cdb_take_branch_0), .cdb_take_branch_1(cdb_take_branch_1),
    .cdb_is_branch_0(cdb_is_branch_0), .cdb_is_branch_1(cdb_is_branch_1),
    .bcast_count_0(bcast_count_0), .bcast_count_1(bcast_count_1),
    .protocol_error(protocol_error));

  always #5 clock = ~clock;

  int lane_ok [2][10] = '{'{0, 2, 4, 6, 9, 11, 12, 14, 17, 19},
                          '{1, 3, 5, 7, 8, 10, 13, 15, 16, 18}};

  // Model of the two CDB lanes as plain records.
  bit                m_valid [2];
  logic [TAG_W-1:0]  m_tag   [2];
  logic [DATA_W-1:0] m_value [2];
  bit                m_tb    [2];
  bit                m_br    [2];
  int                m_cnt   [2];
  bit                m_err;
  bit                m_cap   [2];
  logic [FU_SIZE-1:0] m_ack, seen_ack;

  int vectors = 0, miscompares = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit allowed(input int lane, input int n);
    foreach (lane_ok[lane][j]) if (lane_ok[lane][j] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_tag[k] = '0; m_value[k] = '0; m_tb[k] = 0; m_br[k] = 0; m_cnt[k] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_eval();
    int n [2];
    bit g [2];
    n[0] = int'(fu_num_0); n[1] = int'(fu_num_1);
    g[0] = cat_select_0 != 0; g[1] = cat_select_1 != 0;
    m_ack = '0;
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = !reset && !squash && g[k] && n[k] < FU_SIZE && fu_result_valid[n[k]]
                 && (!m_valid[k] || cdb_ready) && !(k == 1 && g[0] && n[0] == n[1]);
      if (m_cap[k]) m_ack[n[k]] = 1'b1;
    end
  endtask

  task automatic model_edge();
    int n [2];
    logic [FU_CAT-1:0] cs [2];
    n[0] = int'(fu_num_0); n[1] = int'(fu_num_1);
    cs[0] = cat_select_0; cs[1] = cat_select_1;
    for (int k = 0; k < 2; k++) begin
      if (m_valid[k] && cdb_ready && !squash && m_cnt[k] < CNT_MAX) m_cnt[k]++;
      if (cs[k] != 0 && (!allowed(k, n[k]) || $countones(cs[k]) > 1)) m_err = 1;
    end
    if (cs[0] != 0 && cs[1] != 0 && n[0] == n[1]) m_err = 1;
    for (int k = 0; k < 2; k++) begin
      if (squash) m_valid[k] = 0;
      else if (m_cap[k]) begin
        m_valid[k] = 1;
        m_tag[k]   = fu_result_tag[n[k]*TAG_W +: TAG_W];
        m_value[k] = fu_result_value[n[k]*DATA_W +: DATA_W];
        m_tb[k]    = fu_result_take_branch[n[k]];
        m_br[k]    = cs[k][3];
      end else if (cdb_ready) m_valid[k] = 0;
    end
  endtask

  task automatic check_outputs();
    chk("valid0", 64'(cdb_valid_0), 64'(m_valid[0]));
    chk("valid1", 64'(cdb_valid_1), 64'(m_valid[1]));
    if (m_valid[0]) begin
      chk("tag0", 64'(cdb_tag_0), 64'(m_tag[0]));
      chk("value0", 64'(cdb_value_0), 64'(m_value[0]));
      chk("tb0", 64'(cdb_take_branch_0), 64'(m_tb[0]));
      chk("br0", 64'(cdb_is_branch_0), 64'(m_br[0]));
    end
    if (m_valid[1]) begin
      chk("tag1", 64'(cdb_tag_1), 64'(m_tag[1]));
      chk("value1", 64'(cdb_value_1), 64'(m_value[1]));
      chk("tb1", 64'(cdb_take_branch_1), 64'(m_tb[1]));
      chk("br1", 64'(cdb_is_branch_1), 64'(m_br[1]));
    end
    chk("count0", 64'(bcast_count_0), 64'(m_cnt[0]));
    chk("count1", 64'(bcast_count_1), 64'(m_cnt[1]));
    chk("error", 64'(protocol_error), 64'(m_err));
  endtask

  // Inputs are set by the caller while the clock is away from its edges.
  task automatic tick();
    @(negedge clock);
    model_eval();
    seen_ack = fu_result_ack;
    chk("ack", 64'(fu_result_ack), 64'(m_ack));
    @(posedge clock); #1;
    model_edge();
    check_outputs();
    vectors++;
  endtask

  task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                        input bit tb);
    fu_result_valid[i] = 1'b1;
    fu_result_tag[i*TAG_W +: TAG_W] = t;
    fu_result_value[i*DATA_W +: DATA_W] = v;
    fu_result_take_branch[i] = tb;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic random_inputs(input bit allow_err);
    for (int i = 0; i < FU_SIZE; i++) begin
      if (m_ack[i]) fu_result_valid[i] = 1'b0;
      else if (!fu_result_valid[i] && $urandom_range(0, 9) < 3)
        set_fu(i, TAG_W'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end
    fu_num_0 = 5'(lane_ok[0][$urandom_range(0, 9)]);
    fu_num_1 = 5'(lane_ok[1][$urandom_range(0, 9)]);
    cat_select_0 = ($urandom_range(0, 5) < 4) ? FU_CAT'(1 << $urandom_range(0, 3)) : '0;
    cat_select_1 = ($urandom_range(0, 5) < 4) ? FU_CAT'(1 << $urandom_range(0, 3)) : '0;
    if (allow_err) begin
      if ($urandom_range(0, 3) == 0) fu_num_0 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) fu_num_1 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) fu_num_1 = fu_num_0;
      if ($urandom_range(0, 5) == 0) cat_select_0 = FU_CAT'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) cat_select_1 = FU_CAT'($urandom_range(0, 15));
    end
    cdb_ready = $urandom_range(0, 3) != 0;
    squash    = $urandom_range(0, 19) == 0;
  endtask

  initial begin
    model_reset();
    // Reset held: a live request must not be acknowledged.
    set_fu(0, 5'h01, 32'h1, 1'b0);
    fu_num_0 = 5'd0; cat_select_0 = 4'b0001; cdb_ready = 1'b1;
    @(negedge clock);
    chk("rst_ack", 64'(fu_result_ack), 64'h0);
    chk("rst_valid0", 64'(cdb_valid_0), 64'h0);
    chk("rst_count0", 64'(bcast_count_0), 64'h0);
    chk("rst_error", 64'(protocol_error), 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    fu_result_valid = '0; cat_select_0 = '0;

    // Single capture on lane 0.
    set_fu(4, 5'h0A, 32'hDEAD_BEEF, 1'b0);
    fu_num_0 = 5'd4; cat_select_0 = 4'b0001; cdb_ready = 1'b1;
    tick();
    chk("t1_ack", 64'(seen_ack), 64'h00010);
    chk("t1_valid0", 64'(cdb_valid_0), 64'h1);
    chk("t1_tag0", 64'(cdb_tag_0), 64'h0A);
    chk("t1_value0", 64'(cdb_value_0), 64'hDEAD_BEEF);
    chk("t1_br0", 64'(cdb_is_branch_0), 64'h0);
    fu_result_valid[4] = 1'b0; cat_select_0 = '0;
    tick();
    chk("t1_count0", 64'(bcast_count_0), 64'h1);

    // Both lanes at once, branch on lane 0.
    set_fu(17, 5'h11, 32'h0000_1717, 1'b1);
    set_fu(8, 5'h08, 32'h0000_0808, 1'b0);
    fu_num_0 = 5'd17; cat_select_0 = 4'b1000;
    fu_num_1 = 5'd8;  cat_select_1 = 4'b0001;
    tick();
    chk("t2_ack", 64'(seen_ack), 64'h20100);
    chk("t2_valid1", 64'(cdb_valid_1), 64'h1);
    chk("t2_br0", 64'(cdb_is_branch_0), 64'h1);
    chk("t2_tb0", 64'(cdb_take_branch_0), 64'h1);

    // Stall: lane 0 busy, FU 2 waits.
    fu_result_valid = '0;
    set_fu(2, 5'h02, 32'h0000_0202, 1'b0);
    fu_num_0 = 5'd2; cat_select_0 = 4'b0001; cat_select_1 = '0; cdb_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t3_stall_ack", 64'(seen_ack), 64'h0);
      chk("t3_stall_tag0", 64'(cdb_tag_0), 64'h11);
    end
    cdb_ready = 1'b1;
    tick();
    chk("t3_ack", 64'(seen_ack), 64'h00004);
    chk("t3_tag0", 64'(cdb_tag_0), 64'h02);
    chk("t3_count0", 64'(bcast_count_0), 64'h2);
    chk("t3_count1", 64'(bcast_count_1), 64'h1);

    // Squash alongside a valid grant.
    fu_result_valid[2] = 1'b0;
    set_fu(6, 5'h06, 32'h0000_0606, 1'b0);
    fu_num_0 = 5'd6; squash = 1'b1;
    tick();
    chk("t4_ack", 64'(seen_ack), 64'h0);
    chk("t4_valid0", 64'(cdb_valid_0), 64'h0);
    chk("t4_count0", 64'(bcast_count_0), 64'h2);
    chk("t4_count1", 64'(bcast_count_1), 64'h1);

    // Lane 0 granting an odd slot is a protocol error, and it sticks.
    squash = 1'b0; fu_num_0 = 5'd1;
    tick();
    chk("t5_error", 64'(protocol_error), 64'h1);
    cat_select_0 = '0;
    tick(); tick();
    chk("t5_sticky", 64'(protocol_error), 64'h1);

    // Async reset while both lanes hold results.
    fu_result_valid = '0;
    set_fu(0, 5'h10, 32'hA0A0_0000, 1'b0);
    set_fu(3, 5'h13, 32'hB0B0_0003, 1'b1);
    fu_num_0 = 5'd0; cat_select_0 = 4'b0001; fu_num_1 = 5'd3; cat_select_1 = 4'b0010;
    tick();
    chk("t6_pre_valid1", 64'(cdb_valid_1), 64'h1);
    fu_result_valid = '0;
    set_fu(2, 5'h02, 32'h2, 1'b0);
    fu_num_0 = 5'd2; cat_select_0 = 4'b0001; cat_select_1 = '0;
    #1 reset = 1'b1;
    #1;
    chk("t6_ack", 64'(fu_result_ack), 64'h0);
    chk("t6_valid", 64'({cdb_valid_0, cdb_valid_1}), 64'h0);
    chk("t6_tag", 64'({cdb_tag_0, cdb_tag_1}), 64'h0);
    chk("t6_count", 64'({bcast_count_0, bcast_count_1}), 64'h0);
    chk("t6_error", 64'(protocol_error), 64'h0);
    #1 reset = 1'b0;
    model_reset();

    // Randomized legal traffic, then traffic with protocol violations.
    fu_result_valid = '0; m_ack = '0;
    for (int c = 0; c < 500; c++) begin
      random_inputs(1'b0);
      tick();
    end
    pulse_reset();
    fu_result_valid = '0; m_ack = '0;
    for (int c = 0; c < 400; c++) begin
      random_inputs(1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/cdb_broadcast_stage.md
Name: cdb_broadcast_stage

Overview:
- Completion stage directly downstream of the two-lane FU result selector.
- Each cycle it takes the selector's per-lane FU index and category one-hot, and muxes that FU's result (tag, value, branch outcome) into a registered common-data-bus (CDB) lane.
- It returns a one-hot acknowledge to the FUs whose results were captured.
- It handles downstream backpressure, squash, and sticky protocol-error detection, and keeps per-lane broadcast counters.

Parameters:
- FU_SIZE, 20, number of functional-unit result slots.
- FU_CAT, 4, number of FU categories (one-hot category select width).
- TAG_W, 5, ROB/physical tag width.
- DATA_W, 32, result value width.
- CNT_W, 16, width of per-lane broadcast counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- squash  in  1  pipeline flush; kills captures and clears lanes
- cdb_ready  in  1  downstream (ROB/RS) accepts both CDB lanes this cycle
- fu_result_valid  in  FU_SIZE  per-FU result pending
- fu_result_tag  in  FU_SIZE*TAG_W  packed per-FU tags, FU i at [i*TAG_W +: TAG_W]
- fu_result_value  in  FU_SIZE*DATA_W  packed per-FU values
- fu_result_take_branch  in  FU_SIZE  per-FU branch-taken bit
- fu_num_0, fu_num_1  in  5  selected FU index, lanes 0/1
- cat_select_0, cat_select_1  in  FU_CAT  one-hot category grant per lane; all-zero means no grant
- fu_result_ack  out  FU_SIZE  combinational; bit i high means FU i captured this cycle and may drop its result
- cdb_valid_0, cdb_valid_1  out  1  registered lane valid
- cdb_tag_0, cdb_tag_1  out  TAG_W  registered lane tag
- cdb_value_0, cdb_value_1  out  DATA_W  registered lane value
- cdb_take_branch_0, cdb_take_branch_1  out  1  registered branch-taken
- cdb_is_branch_0, cdb_is_branch_1  out  1  registered; the lane came from the branch category (cat_select[3])
- bcast_count_0, bcast_count_1  out  CNT_W  completed broadcasts per lane, saturating
- protocol_error  out  1  sticky error flag

Behaviour:
- Reset (async, high): all cdb_* outputs are 0, counters are 0, protocol_error is 0. fu_result_ack is 0 while reset is high.
- Lane k request: req_k = |cat_select_k AND fu_result_valid[fu_num_k] AND fu_num_k < FU_SIZE.
- Lane k free: free_k = ~cdb_valid_k OR cdb_ready.
- Lane k capture: cap_k = req_k AND free_k AND ~squash AND ~reset.
- fu_result_ack[i] = (cap_0 AND fu_num_0 == i) OR (cap_1 AND fu_num_1 == i).
- Each lane operates independently; one lane may capture while the other holds.
- Latency: a selection presented in cycle N appears on the CDB lane in cycle N+1.
- Lane register update at posedge, in priority order:
  - squash: cdb_valid_k <= 0. Data fields are don't-care but hold.
  - cap_k: cdb_valid_k <= 1 and load tag, value, take_branch and is_branch from FU fu_num_k.
  - cdb_ready: cdb_valid_k <= 0.
  - otherwise: hold all fields.
- Stall: while cdb_valid_k=1 and cdb_ready=0, lane k holds its value, is not acked, and the FU keeps fu_result_valid asserted.
- Counters: bcast_count_k increments when cdb_valid_k AND cdb_ready AND ~squash. It saturates at all-ones and is not cleared by squash.
- protocol_error sets and stays set until reset on any of:
  - both lanes have a grant with fu_num_0 == fu_num_1;
  - lane 0 grants an FU outside {0,2,4,6,9,11,12,14,17,19};
  - lane 1 grants an FU outside {1,3,5,7,8,10,13,15,16,18};
  - a lane grants fu_num >= FU_SIZE;
  - cat_select_k has more than one bit set.
- A lane with an error still captures if req_k holds, except when the two indices are equal: then only lane 0 captures.
- Reset asserted mid-stall drops held results immediately; no ack is issued.

Test Plan:
- Lane 0 selects FU 4 (tag 5'h0A, value 32'hDEAD_BEEF) with cat_select_0=4'b0001, cdb_ready=1 -> fu_result_ack=20'h00010 that cycle; next cycle cdb_valid_0=1, tag 0x0A, value 0xDEADBEEF, is_branch 0; bcast_count_0=1 one cycle later.
- Both lanes in one cycle: FU 17 (branch, take_branch=1) on lane 0 and FU 8 on lane 1 -> ack bits 17 and 8 set; next cycle both lanes valid, cdb_is_branch_0=1, cdb_take_branch_0=1.
- Lane 0 valid, cdb_ready=0 for 3 cycles while FU 2 is requested -> no ack, lane 0 output stable; the cycle cdb_ready returns, FU 2 is acked and appears on the following cycle.
- Squash in the same cycle as a valid grant -> ack=0; next cycle both cdb_valid=0 and counters unchanged.
- Lane 0 fu_num=1 with cat_select_0=4'b0001 -> protocol_error=1 next cycle and remains 1 until reset.
- Async reset pulse mid-cycle while both lanes are valid -> all outputs 0 immediately, without waiting for a clock edge.
